// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target responder.
// Holds the FSM state encoding, bus-level bit meanings and the majority-vote helper.
package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        RX,
        RX_ACK,
        TX,
        TX_ACK,
        WAIT_STOP
    } i2c_state_e;

    localparam logic I2C_ACK   = 1'b0;
    localparam logic I2C_NACK  = 1'b1;
    localparam logic I2C_WRITE = 1'b0;
    localparam logic I2C_READ  = 1'b1;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// Two-flop synchronizer plus edge detect for one I2C pin.
// With I2C_TARGET_GLITCH_FILTER_EN defined, a 3-sample majority filter sits after the synchronizer.
module i2c_line_sync
    import i2c_pkg::*;
(
    input  logic clk_i,
    input  logic rst_ni,
    input  logic pin_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;
    logic level;

    // Flops reset to 1 so an idle (pulled-up) bus produces no edge after reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= pin_i;
            sync2_q <= sync1_q;
        end
    end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
    logic [1:0] hist_q;
    logic       level_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hist_q  <= 2'b11;
            level_q <= 1'b1;
        end else begin
            hist_q  <= {hist_q[0], sync2_q};
            level_q <= majority3(sync2_q, hist_q[0], hist_q[1]);
        end
    end

    assign level = level_q;
`else
    assign level = sync2_q;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prev_q <= 1'b1;
        end else begin
            prev_q <= level;
        end
    end

    assign level_o = level;
    assign rise_o  = level & ~prev_q;
    assign fall_o  = ~level & prev_q;

endmodule

// File: rtl/i2c_target_responder.sv
// I2C target responder: address match, write receive, read transmit, open-drain SDA pull-down.
// Optional line glitch filter enabled by defining I2C_TARGET_GLITCH_FILTER_EN.
module i2c_target_responder
    import i2c_pkg::*;
#(
    parameter logic [6:0] SlaveAddress = 7'b1001011
) (
    input  logic       clock,
    input  logic       Reset,
    input  logic       SCL,
    inout  wire        SDA,
    input  logic [7:0] TxData,
    output logic [7:0] RxData,
    output logic       RxValid,
    output logic       TxRequest,
    output logic       Selected,
    output logic       Busy
);

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;
    logic start_det, stop_det;

    i2c_state_e state_q;
    logic [2:0] bitcnt_q;
    logic [7:0] shift_q;
    logic [7:0] txbyte_q;
    logic       rw_q;
    logic       phase_q;
    logic       sda_low_q;
    logic [7:0] rxdata_q;
    logic       rxvalid_q;
    logic       txreq_q;
    logic       selected_q;
    logic       busy_q;

    i2c_line_sync u_scl_sync (
        .clk_i  (clock),
        .rst_ni (Reset),
        .pin_i  (SCL),
        .level_o(scl_lvl),
        .rise_o (scl_rise),
        .fall_o (scl_fall)
    );

    i2c_line_sync u_sda_sync (
        .clk_i  (clock),
        .rst_ni (Reset),
        .pin_i  (SDA),
        .level_o(sda_lvl),
        .rise_o (sda_rise),
        .fall_o (sda_fall)
    );

    assign start_det = sda_fall & scl_lvl;
    assign stop_det  = sda_rise & scl_lvl;

    // phase_q separates the two falling edges of each ACK slot (drive, then release).
    always_ff @(posedge clock or negedge Reset) begin
        if (!Reset) begin
            state_q    <= IDLE;
            bitcnt_q   <= 3'd0;
            shift_q    <= 8'h00;
            txbyte_q   <= 8'h00;
            rw_q       <= I2C_WRITE;
            phase_q    <= 1'b0;
            sda_low_q  <= 1'b0;
            rxdata_q   <= 8'h00;
            rxvalid_q  <= 1'b0;
            txreq_q    <= 1'b0;
            selected_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            rxvalid_q <= 1'b0;
            txreq_q   <= 1'b0;
            if (start_det) begin
                state_q    <= ADDR;
                bitcnt_q   <= 3'd0;
                phase_q    <= 1'b0;
                sda_low_q  <= 1'b0;
                selected_q <= 1'b0;
                busy_q     <= 1'b1;
            end else if (stop_det) begin
                state_q    <= IDLE;
                phase_q    <= 1'b0;
                sda_low_q  <= 1'b0;
                selected_q <= 1'b0;
                busy_q     <= 1'b0;
            end else begin
                case (state_q)
                    ADDR: begin
                        if (scl_rise) begin
                            shift_q  <= {shift_q[6:0], sda_lvl};
                            bitcnt_q <= bitcnt_q + 3'd1;
                            if (bitcnt_q == 3'd7) begin
                                if (shift_q[6:0] == SlaveAddress) begin
                                    state_q <= ADDR_ACK;
                                    rw_q    <= sda_lvl;
                                    phase_q <= 1'b0;
                                end else begin
                                    state_q <= IDLE;
                                end
                            end
                        end
                    end
                    ADDR_ACK: begin
                        if (scl_fall) begin
                            if (!phase_q) begin
                                sda_low_q  <= 1'b1;
                                selected_q <= 1'b1;
                                phase_q    <= 1'b1;
                            end else begin
                                phase_q  <= 1'b0;
                                bitcnt_q <= 3'd0;
                                if (rw_q == I2C_READ) begin
                                    state_q   <= TX;
                                    txreq_q   <= 1'b1;
                                    txbyte_q  <= TxData;
                                    sda_low_q <= ~TxData[7];
                                end else begin
                                    state_q   <= RX;
                                    sda_low_q <= 1'b0;
                                end
                            end
                        end
                    end
                    RX: begin
                        if (scl_rise) begin
                            shift_q  <= {shift_q[6:0], sda_lvl};
                            bitcnt_q <= bitcnt_q + 3'd1;
                            if (bitcnt_q == 3'd7) begin
                                state_q <= RX_ACK;
                                phase_q <= 1'b0;
                            end
                        end
                    end
                    RX_ACK: begin
                        if (scl_fall) begin
                            if (!phase_q) begin
                                sda_low_q <= 1'b1;
                                rxdata_q  <= shift_q;
                                rxvalid_q <= 1'b1;
                                phase_q   <= 1'b1;
                            end else begin
                                sda_low_q <= 1'b0;
                                phase_q   <= 1'b0;
                                bitcnt_q  <= 3'd0;
                                state_q   <= RX;
                            end
                        end
                    end
                    // txbyte_q[7] is the bit on the wire; shift left to expose the next one.
                    TX: begin
                        if (scl_fall) begin
                            bitcnt_q <= bitcnt_q + 3'd1;
                            if (bitcnt_q == 3'd7) begin
                                sda_low_q <= 1'b0;
                                phase_q   <= 1'b0;
                                state_q   <= TX_ACK;
                            end else begin
                                sda_low_q <= ~txbyte_q[6];
                                txbyte_q  <= {txbyte_q[6:0], 1'b0};
                            end
                        end
                    end
                    TX_ACK: begin
                        if (scl_rise) begin
                            if (sda_lvl == I2C_NACK) begin
                                state_q    <= WAIT_STOP;
                                sda_low_q  <= 1'b0;
                                selected_q <= 1'b0;
                            end else begin
                                phase_q <= 1'b1;
                            end
                        end else if (scl_fall && phase_q) begin
                            phase_q   <= 1'b0;
                            bitcnt_q  <= 3'd0;
                            state_q   <= TX;
                            txreq_q   <= 1'b1;
                            txbyte_q  <= TxData;
                            sda_low_q <= ~TxData[7];
                        end
                    end
                    IDLE, WAIT_STOP: begin
                    end
                    default: begin
                        state_q   <= IDLE;
                        sda_low_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Gate with Reset so the bus is freed in the same cycle reset asserts.
    assign SDA = (sda_low_q && Reset) ? 1'b0 : 1'bz;

    assign RxData    = rxdata_q;
    assign RxValid   = rxvalid_q;
    assign TxRequest = txreq_q;
    assign Selected  = selected_q;
    assign Busy      = busy_q;

endmodule
